// File: rtl/booth16_mult_seq_if.sv
// Operand/result handshake bundle for the sequential radix-16 Booth multiplier.
// The source drives operands and the consumer-side ready; the multiplier drives the rest.
interface booth16_mult_seq_if #(
  parameter int WIDTH = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, product
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, product
  );
endinterface

// File: rtl/booth16_mult_seq.sv
// Sequential signed multiplier: one radix-16 Booth digit per cycle, digit*a formed by shift/add
// and accumulated at weight 16^i. Latency is WIDTH/4 cycles from acceptance to out_valid.
module booth16_mult_seq #(
  parameter  int WIDTH = 16,
  localparam int N     = WIDTH / 4,
  localparam int IW    = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  booth16_mult_seq_if.slave    bus,
  output logic                 busy,
  output logic [4:0]           digit,
  output logic [IW-1:0]        digit_idx
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t                r_state;
  state_t                w_stateNext;
  logic [WIDTH-1:0]      r_a;
  logic [WIDTH-1:0]      r_b;
  logic [2*WIDTH-1:0]    r_acc;
  logic [2*WIDTH-1:0]    r_product;
  logic [4:0]            r_digit;
  logic [IW-1:0]         r_idx;

  logic [IW-1:0]         w_idxNext;
  logic                  w_lastDigit;
  logic [3:0]            w_mag;
  logic [WIDTH+3:0]      w_aExt;
  logic [WIDTH+3:0]      w_partial;
  logic [WIDTH+3:0]      w_term;
  logic [2*WIDTH-1:0]    w_termExt;
  logic [2*WIDTH-1:0]    w_shifted;
  logic [2*WIDTH-1:0]    w_accNext;

  // Signed 4-bit value of {g4..g1} plus the borrow bit g0 gives the digit in [-8, +8].
  function automatic logic [4:0] recode(input logic [WIDTH-1:0] mult, input logic [IW-1:0] idx);
    logic [WIDTH:0] ext;
    logic [4:0]     g;
    ext = {mult, 1'b0};
    g   = ext[{idx, 2'b00} +: 5];
    return {g[4], g[4:1]} + {4'b0000, g[0]};
  endfunction

  assign w_idxNext   = r_idx + IW'(1);
  assign w_lastDigit = (r_idx == IW'(N - 1));

  assign w_mag     = r_digit[4] ? (4'd0 - r_digit[3:0]) : r_digit[3:0];
  assign w_aExt    = {{4{r_a[WIDTH-1]}}, r_a};
  assign w_partial = (w_mag[0] ? w_aExt        : '0)
                   + (w_mag[1] ? (w_aExt << 1) : '0)
                   + (w_mag[2] ? (w_aExt << 2) : '0)
                   + (w_mag[3] ? (w_aExt << 3) : '0);
  assign w_term    = r_digit[4] ? (~w_partial + 1'b1) : w_partial;
  assign w_termExt = {{(WIDTH-4){w_term[WIDTH+3]}}, w_term};
  assign w_shifted = w_termExt << {r_idx, 2'b00};
  assign w_accNext = r_acc + w_shifted;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Handshake outputs are decoded from state only, so ready/valid never see the inputs combinationally.
  always_comb begin
    w_stateNext   = r_state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    busy          = 1'b0;
    case (r_state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) w_stateNext = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (w_lastDigit) w_stateNext = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) w_stateNext = IDLE;
      end
      default: w_stateNext = IDLE;
    endcase
    if (flush) w_stateNext = IDLE;
  end

  // The registered digit always describes the one applied at the next edge, so digit 0 is loaded on acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a       <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_product <= '0;
      r_digit   <= '0;
      r_idx     <= '0;
    end else if (flush) begin
      r_acc   <= '0;
      r_digit <= '0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_acc   <= '0;
            r_digit <= recode(bus.b, '0);
            r_idx   <= '0;
          end
        end
        RUN: begin
          r_acc <= w_accNext;
          if (w_lastDigit) begin
            r_product <= w_accNext;
            r_digit   <= '0;
            r_idx     <= '0;
          end else begin
            r_digit <= recode(r_b, w_idxNext);
            r_idx   <= w_idxNext;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.product = r_product;
  assign digit       = r_digit;
  assign digit_idx   = r_idx;

endmodule
